// File: rtl/tick_timer_pkg.sv
// Shared types and defaults for the tick_timer block.
package tick_timer_pkg;

   localparam int TT_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_RUN     = 2'b01,
      ST_EXPIRED = 2'b10
   } tt_state_e;

endpackage

// File: rtl/tick_timer_if.sv
// Command/status bundle between a controller and the tick_timer.
interface tick_timer_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] load_val;
   logic             load;
   logic             start;
   logic             stop;
   logic             periodic;
   logic             tick;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] count;

   modport master (
      output load_val, load, start, stop, periodic,
      input  tick, busy, done, count
   );

   modport slave (
      input  load_val, load, start, stop, periodic,
      output tick, busy, done, count
   );
endinterface

// File: rtl/tick_timer_down_counter.sv
// Loadable down-counter with zero flag; load wins over decrement and it never wraps below zero.
module loadable_down_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic [WIDTH-1:0] count,
   output logic             zero
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign zero  = (count_q == '0);

endmodule

// File: rtl/tick_timer.sv
// Programmable countdown timer producing one-cycle tick strobes, periodic or one-shot.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   ST_IDLE    | not counting, count held
//   ST_RUN     | counting down, tick on terminal count
//   ST_EXPIRED | one-shot finished, count=0, done=1
//   2'b11      | unreachable, recovers to ST_IDLE
module tick_timer
   import tick_timer_pkg::*;
#(
   parameter int WIDTH = TT_WIDTH
) (
   input  logic         clk,
   input  logic         rst_n,
   tick_timer_if.slave  bus
);

   tt_state_e        state_q;
   tt_state_e        state_d;
   logic             tick_q;
   logic             tick_d;
   logic [WIDTH-1:0] reload_q;
   logic [WIDTH-1:0] reload_d;

   logic             cnt_load;
   logic [WIDTH-1:0] cnt_val;
   logic             cnt_dec;
   logic [WIDTH-1:0] cnt_count;
   logic             cnt_zero;

   loadable_down_counter #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .count    (cnt_count),
      .zero     (cnt_zero)
   );

   // Command priority: stop > load > start; stop and load suppress the terminal tick.
   always_comb begin
      state_d  = state_q;
      tick_d   = 1'b0;
      reload_d = reload_q;
      cnt_load = 1'b0;
      cnt_val  = reload_q;
      cnt_dec  = 1'b0;

      if (bus.stop) begin
         state_d = ST_IDLE;
      end else if (bus.load) begin
         reload_d = bus.load_val;
         cnt_load = 1'b1;
         cnt_val  = bus.load_val;
         if (state_q != ST_RUN) begin
            state_d = ST_IDLE;
         end
      end else begin
         case (state_q)
            ST_IDLE, ST_EXPIRED: begin
               if (bus.start) begin
                  cnt_load = 1'b1;
                  state_d  = ST_RUN;
               end
            end
            ST_RUN: begin
               if (cnt_zero) begin
                  tick_d = 1'b1;
                  if (bus.periodic) begin
                     cnt_load = 1'b1;
                  end else begin
                     state_d = ST_EXPIRED;
                  end
               end else begin
                  cnt_dec = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         tick_q   <= 1'b0;
         reload_q <= '0;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         reload_q <= reload_d;
      end
   end

   assign bus.tick  = tick_q;
   assign bus.busy  = (state_q == ST_RUN);
   assign bus.done  = (state_q == ST_EXPIRED);
   assign bus.count = cnt_count;

endmodule

// File: tb/tb_tick_timer.sv
// Directed bench for tick_timer: a 16-bit instance for the command/timing cases, a 4-bit one for wrap.
module tb_tick_timer;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   tick_timer_if #(.WIDTH(16)) bus_a ();
   tick_timer_if #(.WIDTH(4))  bus_b ();

   tick_timer #(.WIDTH(16)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   tick_timer #(.WIDTH(4)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic [15:0] cnt, input logic tk,
                        input logic bz, input logic dn);
      chk({tag, ".count"}, 32'(bus_a.count), 32'(cnt));
      chk({tag, ".tick"},  32'(bus_a.tick),  32'(tk));
      chk({tag, ".busy"},  32'(bus_a.busy),  32'(bz));
      chk({tag, ".done"},  32'(bus_a.done),  32'(dn));
   endtask

   task automatic clr_cmds();
      bus_a.load  = 1'b0;
      bus_a.start = 1'b0;
      bus_a.stop  = 1'b0;
      bus_b.load  = 1'b0;
      bus_b.start = 1'b0;
      bus_b.stop  = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      bus_a.load_val = '0;
      bus_a.periodic = 1'b0;
      bus_b.load_val = '0;
      bus_b.periodic = 1'b0;
      clr_cmds();

      #3;
      chk_a("por", 16'd0, 1'b0, 1'b0, 1'b0);
      #4 rst_n = 1'b1;
      cyc();
      chk_a("idle_after_rst", 16'd0, 1'b0, 1'b0, 1'b0);

      // Periodic, N=3: tick every 4 cycles after the start edge.
      bus_a.load_val = 16'd3;
      bus_a.load = 1'b1;
      cyc();
      clr_cmds();
      chk_a("per_load", 16'd3, 1'b0, 1'b0, 1'b0);
      bus_a.start = 1'b1;
      bus_a.periodic = 1'b1;
      cyc();
      clr_cmds();
      chk_a("per_e0", 16'd3, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         cyc();
         if (k % 4 == 0) chk_a($sformatf("per_e%0d", k), 16'd3, 1'b1, 1'b1, 1'b0);
         else            chk_a($sformatf("per_e%0d", k), 16'(3 - (k % 4)), 1'b0, 1'b1, 1'b0);
      end

      // stop+load+start together while RUN (count=3): stop wins, reload stays 3.
      bus_a.stop = 1'b1;
      bus_a.load = 1'b1;
      bus_a.load_val = 16'd9;
      bus_a.start = 1'b1;
      cyc();
      clr_cmds();
      chk_a("sls", 16'd3, 1'b0, 1'b0, 1'b0);
      bus_a.start = 1'b1;
      cyc();
      clr_cmds();
      chk_a("sls_restart", 16'd3, 1'b0, 1'b1, 1'b0);

      // load on the terminal-count edge: reloads with the new value, no tick.
      cyc();
      cyc();
      cyc();
      chk_a("pre_term", 16'd0, 1'b0, 1'b1, 1'b0);
      bus_a.load_val = 16'd7;
      bus_a.load = 1'b1;
      cyc();
      clr_cmds();
      chk_a("load_at_term", 16'd7, 1'b0, 1'b1, 1'b0);
      cyc();
      chk_a("after_load_term", 16'd6, 1'b0, 1'b1, 1'b0);
      bus_a.stop = 1'b1;
      cyc();
      clr_cmds();
      chk_a("stop_freeze", 16'd6, 1'b0, 1'b0, 1'b0);
      cyc();
      chk_a("stop_hold", 16'd6, 1'b0, 1'b0, 1'b0);

      // One-shot, N=2: single tick 3 cycles after start, then EXPIRED held.
      bus_a.load_val = 16'd2;
      bus_a.load = 1'b1;
      cyc();
      clr_cmds();
      bus_a.start = 1'b1;
      bus_a.periodic = 1'b0;
      cyc();
      clr_cmds();
      chk_a("os_e0", 16'd2, 1'b0, 1'b1, 1'b0);
      cyc();
      chk_a("os_e1", 16'd1, 1'b0, 1'b1, 1'b0);
      cyc();
      chk_a("os_e2", 16'd0, 1'b0, 1'b1, 1'b0);
      cyc();
      chk_a("os_e3", 16'd0, 1'b1, 1'b0, 1'b1);
      for (int k = 4; k <= 8; k++) begin
         cyc();
         chk_a($sformatf("os_hold%0d", k), 16'd0, 1'b0, 1'b0, 1'b1);
      end
      bus_a.load_val = 16'd5;
      bus_a.load = 1'b1;
      cyc();
      clr_cmds();
      chk_a("os_load_exp", 16'd5, 1'b0, 1'b0, 1'b0);

      // Zero period: tick continuously high, then stop drops it.
      bus_a.load_val = 16'd0;
      bus_a.load = 1'b1;
      cyc();
      clr_cmds();
      bus_a.start = 1'b1;
      bus_a.periodic = 1'b1;
      cyc();
      clr_cmds();
      chk_a("z_e0", 16'd0, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         cyc();
         chk_a($sformatf("z_e%0d", k), 16'd0, 1'b1, 1'b1, 1'b0);
      end
      bus_a.stop = 1'b1;
      cyc();
      clr_cmds();
      chk_a("z_stop", 16'd0, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset mid-RUN with count=5.
      bus_a.load_val = 16'd9;
      bus_a.load = 1'b1;
      cyc();
      clr_cmds();
      bus_a.start = 1'b1;
      cyc();
      clr_cmds();
      for (int k = 0; k < 4; k++) cyc();
      chk_a("rst_pre", 16'd5, 1'b0, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk_a("rst_async", 16'd0, 1'b0, 1'b0, 1'b0);
      #3 rst_n = 1'b1;
      for (int k = 0; k < 3; k++) cyc();
      chk_a("rst_idle", 16'd0, 1'b0, 1'b0, 1'b0);

      // 4-bit wrap: N=15, tick every 16 cycles, 15..0 then 15.
      bus_b.load_val = 4'd15;
      bus_b.load = 1'b1;
      cyc();
      clr_cmds();
      bus_b.start = 1'b1;
      bus_b.periodic = 1'b1;
      cyc();
      clr_cmds();
      chk("w_e0.count", 32'(bus_b.count), 32'd15);
      for (int k = 1; k <= 32; k++) begin
         cyc();
         if (k % 16 == 0) begin
            chk($sformatf("w_e%0d.count", k), 32'(bus_b.count), 32'd15);
            chk($sformatf("w_e%0d.tick", k),  32'(bus_b.tick),  32'd1);
         end else begin
            chk($sformatf("w_e%0d.count", k), 32'(bus_b.count), 32'(15 - (k % 16)));
            chk($sformatf("w_e%0d.tick", k),  32'(bus_b.tick),  32'd0);
         end
         chk($sformatf("w_e%0d.busy", k), 32'(bus_b.busy), 32'd1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
